avalon_pkt_gen: RTL and testbench

Avalon-ST packet transmitter: accepts a packet command (byte length, seed) and emits one framed packet on an `avalon_st_if.master` port with sop/eop/empty and a deterministic incrementing-byte payload, honouring downstream backpressure. It sits at the source end of the same Avalon-ST links the sampler/skid stages buffer. It serves as a traffic source for bring-up and for benches that drive those stages.

---
 rtl/avalon_st_if.sv | 30 +++
 rtl/avalon_pkt_gen.sv | 173 +++++++++++++++++
 tb/tb_avalon_pkt_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_st_if.sv
// Avalon-ST link bundle shared by the packet generator and the
// sampler/skid stages downstream of it.
//
// Parameters:
//   DATA_WIDTH  beat width in bits (multiple of 8)
// Signals:
//   data   beat payload, byte 0 of the beat in the MSBs
//   empty  unused bytes on the eop beat; 1 bit, tied 0, when a beat is one byte
//   sop    first beat of a packet
//   eop    last beat of a packet
//   vld    source has a beat on the bus
//   rdy    sink accepts the beat this cycle
interface avalon_st_if #(
  parameter int DATA_WIDTH = 32
);

  localparam int BPB         = DATA_WIDTH / 8;
  localparam int EMPTY_WIDTH = (BPB > 1) ? $clog2(BPB) : 1;

  logic [DATA_WIDTH-1:0]  data;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   sop;
  logic                   eop;
  logic                   vld;
  logic                   rdy;

  modport master (output data, empty, sop, eop, vld, input rdy);
  modport slave  (input data, empty, sop, eop, vld, output rdy);

endinterface

// File: rtl/avalon_pkt_gen.sv
// Avalon-ST packet transmitter. Takes a (length, seed) command and emits one
// framed packet whose payload byte k is (seed + k) mod 256, honouring
// downstream backpressure.
//
// Parameters:
//   LEN_WIDTH  width of the byte-length field of a command
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   cmd_vld    command valid
//   cmd_rdy    command ready (high whenever no packet is in flight)
//   cmd_len    packet length in bytes; zero-length commands are dropped
//   cmd_seed   value of payload byte 0
//   msg_out    Avalon-ST master port, all fields registered
//   busy       a packet is in flight
//   pkt_count  packets whose eop beat has transferred (wraps)
module avalon_pkt_gen #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [7:0]           cmd_seed,
  avalon_st_if.master          msg_out,
  output logic                 busy,
  output logic [31:0]          pkt_count
);

  localparam int DATA_WIDTH = msg_out.DATA_WIDTH;
  localparam int BPB        = DATA_WIDTH / 8;
  localparam int EW         = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int LW1        = LEN_WIDTH + 1;
  localparam logic [LEN_WIDTH:0] BPB_L = LW1'(BPB);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_width_check
    $fatal(1, "avalon_pkt_gen: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, next_state;

  // Lengths, pointers and beat counts carry one extra bit so a maximal
  // cmd_len plus the partial-beat round-up never overflows.
  logic [LEN_WIDTH:0] len_q;
  logic [7:0]         seed_q;
  logic [LEN_WIDTH:0] beats_left;
  logic [LEN_WIDTH:0] byte_ptr;

  logic               start;
  logic               advance;
  logic               finish;
  logic [LEN_WIDTH:0] cmd_beats;

  logic [LEN_WIDTH:0]    src_ptr;
  logic [LEN_WIDTH:0]    src_len;
  logic [7:0]            src_seed;
  logic                  src_last;
  logic [LEN_WIDTH:0]    byte_idx;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [EW-1:0]         beat_empty;

  assign cmd_beats = ({1'b0, cmd_len} + BPB_L - LW1'(1)) / BPB_L;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and the per-cycle load/advance/finish strobes. cmd_rdy
  // and busy are pure functions of the state so the command side never sees
  // a path from msg_out.rdy.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    cmd_rdy    = (state == IDLE);
    busy       = (state == SEND);
    case (state)
      IDLE: begin
        if (cmd_vld && cmd_len != '0) begin
          start      = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (msg_out.rdy) begin
          if (beats_left > LW1'(1)) begin
            advance = 1'b1;
          end else begin
            finish     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // One beat builder serves both the first beat (straight from the command
  // inputs) and every following beat (from the latched command).
  always_comb begin
    if (state == IDLE) begin
      src_ptr  = '0;
      src_len  = {1'b0, cmd_len};
      src_seed = cmd_seed;
      src_last = (cmd_beats == LW1'(1));
    end else begin
      src_ptr  = byte_ptr + BPB_L;
      src_len  = len_q;
      src_seed = seed_q;
      src_last = (beats_left == LW1'(2));
    end
  end

  // Byte j of a beat sits in the MSB-first lane j; bytes past the packet end
  // are zero. Empty is only meaningful on the eop beat.
  always_comb begin
    beat_data = '0;
    byte_idx  = '0;
    for (int j = 0; j < BPB; j++) begin
      byte_idx = src_ptr + LW1'(j);
      if (byte_idx < src_len) begin
        beat_data[DATA_WIDTH-1-8*j -: 8] = src_seed + byte_idx[7:0];
      end
    end
    beat_empty = src_last ? EW'(src_ptr + BPB_L - src_len) : '0;
  end

  // Output and datapath registers. Nothing changes while a beat is stalled,
  // which keeps data/empty/sop/eop bit-stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_out.vld   <= 1'b0;
      msg_out.data  <= '0;
      msg_out.empty <= '0;
      msg_out.sop   <= 1'b0;
      msg_out.eop   <= 1'b0;
      len_q         <= '0;
      seed_q        <= '0;
      beats_left    <= '0;
      byte_ptr      <= '0;
      pkt_count     <= '0;
    end else if (start) begin
      len_q         <= {1'b0, cmd_len};
      seed_q        <= cmd_seed;
      beats_left    <= cmd_beats;
      byte_ptr      <= '0;
      msg_out.vld   <= 1'b1;
      msg_out.data  <= beat_data;
      msg_out.empty <= beat_empty;
      msg_out.sop   <= 1'b1;
      msg_out.eop   <= src_last;
    end else if (advance) begin
      beats_left    <= beats_left - LW1'(1);
      byte_ptr      <= src_ptr;
      msg_out.data  <= beat_data;
      msg_out.empty <= beat_empty;
      msg_out.sop   <= 1'b0;
      msg_out.eop   <= src_last;
    end else if (finish) begin
      msg_out.vld   <= 1'b0;
      msg_out.sop   <= 1'b0;
      msg_out.eop   <= 1'b0;
      pkt_count     <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_avalon_pkt_gen.sv
// Directed bench for avalon_pkt_gen with a 32-bit bus (4 bytes per beat).
// Each task drives one scenario and compares the bus against hand-computed
// beats packed as {vld, sop, eop, empty[1:0], data[31:0]}.
module tb_avalon_pkt_gen;

  logic        clk;
  logic        rst_n;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_seed;
  logic        busy;
  logic [31:0] pkt_count;

  int compared;
  int mismatched;

  avalon_st_if #(.DATA_WIDTH(32)) bus ();

  avalon_pkt_gen #(.LEN_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_len   (cmd_len),
    .cmd_seed  (cmd_seed),
    .msg_out   (bus),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to 1 time unit after the next rising edge; all checks and
  // input changes happen there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] bus_word();
    return {bus.vld, bus.sop, bus.eop, bus.empty, bus.data};
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    cmd_vld  = 1'b0;
    cmd_len  = '0;
    cmd_seed = '0;
    bus.rdy  = 1'b0;
    step();
    compared++;
    if (bus_word() !== 37'h0) begin
      mismatched++;
      $display("FAIL reset_bus: got %h expected %h", bus_word(), 37'h0);
    end
    compared++;
    if ({cmd_rdy, busy, pkt_count} !== {1'b1, 1'b0, 32'd0}) begin
      mismatched++;
      $display("FAIL reset_ctrl: got rdy=%b busy=%b cnt=%0d expected rdy=1 busy=0 cnt=0",
               cmd_rdy, busy, pkt_count);
    end
    rst_n   = 1'b1;
    bus.rdy = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [36:0] exp_beat [3];
    exp_beat[0] = {1'b1, 1'b1, 1'b0, 2'd0, 32'hA0A1A2A3};
    exp_beat[1] = {1'b1, 1'b0, 1'b0, 2'd0, 32'hA4A5A6A7};
    exp_beat[2] = {1'b1, 1'b0, 1'b1, 2'd2, 32'hA8A90000};
    cmd_vld  = 1'b1;
    cmd_len  = 16'd10;
    cmd_seed = 8'hA0;
    step();
    cmd_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (bus_word() !== exp_beat[i]) begin
        mismatched++;
        $display("FAIL basic_beat%0d: got %h expected %h", i, bus_word(), exp_beat[i]);
      end
      step();
    end
    compared++;
    if ({bus.vld, cmd_rdy, pkt_count} !== {1'b0, 1'b1, 32'd1}) begin
      mismatched++;
      $display("FAIL basic_end: got vld=%b rdy=%b cnt=%0d expected vld=0 rdy=1 cnt=1",
               bus.vld, cmd_rdy, pkt_count);
    end
  endtask

  task automatic test_seed_wrap();
    cmd_vld  = 1'b1;
    cmd_len  = 16'd4;
    cmd_seed = 8'hFE;
    step();
    cmd_vld = 1'b0;
    compared++;
    if (bus_word() !== {1'b1, 1'b1, 1'b1, 2'd0, 32'hFEFF0001}) begin
      mismatched++;
      $display("FAIL wrap_beat: got %h expected %h", bus_word(),
               {1'b1, 1'b1, 1'b1, 2'd0, 32'hFEFF0001});
    end
    step();
    compared++;
    if ({bus.vld, pkt_count} !== {1'b0, 32'd2}) begin
      mismatched++;
      $display("FAIL wrap_end: got vld=%b cnt=%0d expected vld=0 cnt=2", bus.vld, pkt_count);
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] exp_beat [3];
    int          exp_idx [6];
    logic        rdy_pat [6];
    exp_beat[0] = {1'b1, 1'b1, 1'b0, 2'd0, 32'h00010203};
    exp_beat[1] = {1'b1, 1'b0, 1'b0, 2'd0, 32'h04050607};
    exp_beat[2] = {1'b1, 1'b0, 1'b1, 2'd3, 32'h08000000};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_idx = '{0, 1, 1, 1, 2, 2};
    cmd_vld  = 1'b1;
    cmd_len  = 16'd9;
    cmd_seed = 8'h00;
    step();
    cmd_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (bus_word() !== exp_beat[exp_idx[i]]) begin
        mismatched++;
        $display("FAIL bp_cycle%0d: got %h expected %h", i, bus_word(), exp_beat[exp_idx[i]]);
      end
      bus.rdy = rdy_pat[i];
      step();
    end
    bus.rdy = 1'b1;
    compared++;
    if ({bus.vld, busy, pkt_count} !== {1'b0, 1'b0, 32'd3}) begin
      mismatched++;
      $display("FAIL bp_end: got vld=%b busy=%b cnt=%0d expected vld=0 busy=0 cnt=3",
               bus.vld, busy, pkt_count);
    end
  endtask

  task automatic test_zero_len();
    cmd_vld  = 1'b1;
    cmd_len  = 16'd0;
    cmd_seed = 8'h55;
    step();
    cmd_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if ({bus.vld, cmd_rdy, busy, pkt_count} !== {1'b0, 1'b1, 1'b0, 32'd3}) begin
        mismatched++;
        $display("FAIL zero_len%0d: got vld=%b rdy=%b busy=%b cnt=%0d expected vld=0 rdy=1 busy=0 cnt=3",
                 i, bus.vld, cmd_rdy, busy, pkt_count);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    // Two len=8 packets from a held command: sop at cycles 0 and 3, with a
    // single idle cycle between them. pkt_count continues from 3.
    logic [36:0] exp_beat [5];
    exp_beat[0] = {1'b1, 1'b1, 1'b0, 2'd0, 32'h10111213};
    exp_beat[1] = {1'b1, 1'b0, 1'b1, 2'd0, 32'h14151617};
    exp_beat[2] = '0;
    exp_beat[3] = {1'b1, 1'b1, 1'b0, 2'd0, 32'h10111213};
    exp_beat[4] = {1'b1, 1'b0, 1'b1, 2'd0, 32'h14151617};
    cmd_vld  = 1'b1;
    cmd_len  = 16'd8;
    cmd_seed = 8'h10;
    step();
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (i == 2) begin
        if ({bus.vld, cmd_rdy} !== 2'b01) begin
          mismatched++;
          $display("FAIL b2b_gap: got vld=%b rdy=%b expected vld=0 rdy=1", bus.vld, cmd_rdy);
        end
      end else if (bus_word() !== exp_beat[i]) begin
        mismatched++;
        $display("FAIL b2b_cycle%0d: got %h expected %h", i, bus_word(), exp_beat[i]);
      end
      if (i == 4) cmd_vld = 1'b0;
      step();
    end
    compared++;
    if ({bus.vld, pkt_count} !== {1'b0, 32'd5}) begin
      mismatched++;
      $display("FAIL b2b_end: got vld=%b cnt=%0d expected vld=0 cnt=5", bus.vld, pkt_count);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [36:0] exp_beat [2];
    cmd_vld  = 1'b1;
    cmd_len  = 16'd16;
    cmd_seed = 8'h40;
    step();
    cmd_vld = 1'b0;
    compared++;
    if (bus_word() !== {1'b1, 1'b1, 1'b0, 2'd0, 32'h40414243}) begin
      mismatched++;
      $display("FAIL rst_sop: got %h expected %h", bus_word(),
               {1'b1, 1'b1, 1'b0, 2'd0, 32'h40414243});
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({bus_word(), busy, cmd_rdy, pkt_count} !== {37'h0, 1'b0, 1'b1, 32'd0}) begin
      mismatched++;
      $display("FAIL rst_async: got bus=%h busy=%b rdy=%b cnt=%0d expected bus=0 busy=0 rdy=1 cnt=0",
               bus_word(), busy, cmd_rdy, pkt_count);
    end
    #1;
    rst_n = 1'b1;
    step();
    exp_beat[0] = {1'b1, 1'b1, 1'b0, 2'd0, 32'h7F808182};
    exp_beat[1] = {1'b1, 1'b0, 1'b1, 2'd3, 32'h83000000};
    cmd_vld  = 1'b1;
    cmd_len  = 16'd5;
    cmd_seed = 8'h7F;
    step();
    cmd_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (bus_word() !== exp_beat[i]) begin
        mismatched++;
        $display("FAIL rst_next_beat%0d: got %h expected %h", i, bus_word(), exp_beat[i]);
      end
      step();
    end
    compared++;
    if ({bus.vld, pkt_count} !== {1'b0, 32'd1}) begin
      mismatched++;
      $display("FAIL rst_next_end: got vld=%b cnt=%0d expected vld=0 cnt=1", bus.vld, pkt_count);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_seed_wrap();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
